// File: rtl/tl_instruction_decode_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tl_instruction_decode_pkg                                        |
// | Opcodes, ALUOp encodings and main-control decode for ID stage.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tl_instruction_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  // Unlisted opcodes fall through to an all-zero bundle, i.e. a NOP.
  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_ADD;
      end
      OP_J: begin
        c.jump = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tl_instruction_decode_register_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tl_instruction_decode_register_bank                              |
// | 32-entry register file, two async read ports with WB bypass.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tl_instruction_decode_register_bank #(
  parameter int len     = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_REGS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_ADDR-1:0] i_rs_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  input  logic               i_reg_write,
  input  logic [NB_ADDR-1:0] i_write_reg,
  input  logic [len-1:0]     i_write_data,
  output logic [len-1:0]     o_rs_data,
  output logic [len-1:0]     o_rt_data
);

  logic [len-1:0] r_regs [NB_REGS];
  logic           w_wr_en;

  assign w_wr_en = i_reg_write && (i_write_reg != '0);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < NB_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[i_write_reg] <= i_write_data;
    end
  end

  // $0 is hardwired; a same-cycle WB to the read address is forwarded.
  always_comb begin
    o_rs_data = r_regs[i_rs_addr];
    o_rt_data = r_regs[i_rt_addr];
    if (w_wr_en && (i_write_reg == i_rs_addr)) o_rs_data = i_write_data;
    if (w_wr_en && (i_write_reg == i_rt_addr)) o_rt_data = i_write_data;
    if (i_rs_addr == '0) o_rs_data = '0;
    if (i_rt_addr == '0) o_rt_data = '0;
  end

endmodule
`default_nettype wire

// File: rtl/tl_instruction_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tl_instruction_decode                                            |
// | ID stage: register read, control decode, imm/jump, ID/EX latch.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tl_instruction_decode
  import tl_instruction_decode_pkg::*;
#(
  parameter int len     = 32,
  parameter int NB_ADDR = 5,
  parameter int NB_REGS = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [len-1:0]     i_instruccion,
  input  logic [len-1:0]     i_adder,
  input  logic               i_reg_write,
  input  logic [NB_ADDR-1:0] i_write_reg,
  input  logic [len-1:0]     i_write_data,
  input  logic               i_stall,
  input  logic               i_flush,
  output logic [len-1:0]     o_adder,
  output logic [len-1:0]     o_read_data_1,
  output logic [len-1:0]     o_read_data_2,
  output logic [len-1:0]     o_sign_extend,
  output logic [NB_ADDR-1:0] o_rt,
  output logic [NB_ADDR-1:0] o_rd,
  output logic [len-1:0]     o_jump_dir,
  output logic               o_RegDst,
  output logic               o_ALUSrc,
  output logic               o_Branch,
  output logic               o_MemRead,
  output logic               o_MemWrite,
  output logic               o_MemtoReg,
  output logic               o_RegWrite,
  output logic               o_Jump,
  output logic [1:0]         o_ALUOp
);

  logic [len-1:0]     w_rs_data;
  logic [len-1:0]     w_rt_data;
  logic [len-1:0]     w_sign_extend;
  logic [len-1:0]     w_jump_dir;
  ctrl_t              w_ctrl;

  logic [len-1:0]     r_adder;
  logic [len-1:0]     r_read_data_1;
  logic [len-1:0]     r_read_data_2;
  logic [len-1:0]     r_sign_extend;
  logic [NB_ADDR-1:0] r_rt;
  logic [NB_ADDR-1:0] r_rd;
  logic [len-1:0]     r_jump_dir;
  ctrl_t              r_ctrl;

  tl_instruction_decode_register_bank #(
    .len     (len),
    .NB_ADDR (NB_ADDR),
    .NB_REGS (NB_REGS)
  ) u_register_bank (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rs_addr    (i_instruccion[25:21]),
    .i_rt_addr    (i_instruccion[20:16]),
    .i_reg_write  (i_reg_write),
    .i_write_reg  (i_write_reg),
    .i_write_data (i_write_data),
    .o_rs_data    (w_rs_data),
    .o_rt_data    (w_rt_data)
  );

  assign w_ctrl        = decode_ctrl(i_instruccion[31:26]);
  assign w_sign_extend = {{(len-16){i_instruccion[15]}}, i_instruccion[15:0]};
  assign w_jump_dir    = {i_adder[len-1:len-4], i_instruccion[25:0], 2'b00};

  // Flush outranks stall so a bubble can be injected while the pipe is held.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_adder       <= '0;
      r_read_data_1 <= '0;
      r_read_data_2 <= '0;
      r_sign_extend <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_jump_dir    <= '0;
      r_ctrl        <= '0;
    end else if (i_flush) begin
      r_adder       <= '0;
      r_read_data_1 <= '0;
      r_read_data_2 <= '0;
      r_sign_extend <= '0;
      r_rt          <= '0;
      r_rd          <= '0;
      r_jump_dir    <= '0;
      r_ctrl        <= '0;
    end else if (!i_stall) begin
      r_adder       <= i_adder;
      r_read_data_1 <= w_rs_data;
      r_read_data_2 <= w_rt_data;
      r_sign_extend <= w_sign_extend;
      r_rt          <= i_instruccion[20:16];
      r_rd          <= i_instruccion[15:11];
      r_jump_dir    <= w_jump_dir;
      r_ctrl        <= w_ctrl;
    end
  end

  assign o_adder       = r_adder;
  assign o_read_data_1 = r_read_data_1;
  assign o_read_data_2 = r_read_data_2;
  assign o_sign_extend = r_sign_extend;
  assign o_rt          = r_rt;
  assign o_rd          = r_rd;
  assign o_jump_dir    = r_jump_dir;
  assign o_RegDst      = r_ctrl.reg_dst;
  assign o_ALUSrc      = r_ctrl.alu_src;
  assign o_Branch      = r_ctrl.branch;
  assign o_MemRead     = r_ctrl.mem_read;
  assign o_MemWrite    = r_ctrl.mem_write;
  assign o_MemtoReg    = r_ctrl.mem_to_reg;
  assign o_RegWrite    = r_ctrl.reg_write;
  assign o_Jump        = r_ctrl.jump;
  assign o_ALUOp       = r_ctrl.alu_op;

endmodule
`default_nettype wire

// File: tb/tb_tl_instruction_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tl_instruction_decode                                         |
// | Directed + random stimulus against a behavioural ID-stage model. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_tl_instruction_decode;

  logic        i_clk;
  logic        i_rst;
  logic [31:0] i_instruccion;
  logic [31:0] i_adder;
  logic        i_reg_write;
  logic [4:0]  i_write_reg;
  logic [31:0] i_write_data;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] o_adder, o_read_data_1, o_read_data_2, o_sign_extend, o_jump_dir;
  logic [4:0]  o_rt, o_rd;
  logic        o_RegDst, o_ALUSrc, o_Branch, o_MemRead, o_MemWrite;
  logic        o_MemtoReg, o_RegWrite, o_Jump;
  logic [1:0]  o_ALUOp;

  int n_tests;
  int n_fail;

  // Model state
  logic [31:0] m_regs [32];
  logic [31:0] e_adder, e_rd1, e_rd2, e_sext, e_jdir;
  logic [4:0]  e_rt, e_rd;
  logic [9:0]  e_ctrl;

  tl_instruction_decode dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_instruccion (i_instruccion),
    .i_adder       (i_adder),
    .i_reg_write   (i_reg_write),
    .i_write_reg   (i_write_reg),
    .i_write_data  (i_write_data),
    .i_stall       (i_stall),
    .i_flush       (i_flush),
    .o_adder       (o_adder),
    .o_read_data_1 (o_read_data_1),
    .o_read_data_2 (o_read_data_2),
    .o_sign_extend (o_sign_extend),
    .o_rt          (o_rt),
    .o_rd          (o_rd),
    .o_jump_dir    (o_jump_dir),
    .o_RegDst      (o_RegDst),
    .o_ALUSrc      (o_ALUSrc),
    .o_Branch      (o_Branch),
    .o_MemRead     (o_MemRead),
    .o_MemWrite    (o_MemWrite),
    .o_MemtoReg    (o_MemtoReg),
    .o_RegWrite    (o_RegWrite),
    .o_Jump        (o_Jump),
    .o_ALUOp       (o_ALUOp)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Control bundle order: RegDst ALUSrc Branch MemRead MemWrite MemtoReg RegWrite Jump ALUOp[1:0]
  function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'd0:  return 10'b1000001010;
      6'h23: return 10'b0101011000;
      6'h2B: return 10'b0100100000;
      6'h04: return 10'b0010000001;
      6'h08: return 10'b0100001000;
      6'h02: return 10'b0000000100;
      default: return 10'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (i_reg_write && i_write_reg == a) return i_write_data;
    return m_regs[a];
  endfunction

  function automatic logic [9:0] dut_ctrl();
    return {o_RegDst, o_ALUSrc, o_Branch, o_MemRead, o_MemWrite,
            o_MemtoReg, o_RegWrite, o_Jump, o_ALUOp};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    e_adder = 0; e_rd1 = 0; e_rd2 = 0; e_sext = 0; e_jdir = 0;
    e_rt = 0; e_rd = 0; e_ctrl = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".adder"}, o_adder, e_adder);
    check({tag, ".rd1"},   o_read_data_1, e_rd1);
    check({tag, ".rd2"},   o_read_data_2, e_rd2);
    check({tag, ".sext"},  o_sign_extend, e_sext);
    check({tag, ".rt"},    {27'h0, o_rt}, {27'h0, e_rt});
    check({tag, ".rd"},    {27'h0, o_rd}, {27'h0, e_rd});
    check({tag, ".jdir"},  o_jump_dir, e_jdir);
    check({tag, ".ctrl"},  {22'h0, dut_ctrl()}, {22'h0, e_ctrl});
  endtask

  // Predict the latch contents for the coming edge, advance, then compare.
  task automatic cycle(input string tag);
    logic [31:0] ins;
    ins = i_instruccion;
    if (i_flush) begin
      e_adder = 0; e_rd1 = 0; e_rd2 = 0; e_sext = 0; e_jdir = 0;
      e_rt = 0; e_rd = 0; e_ctrl = 0;
    end else if (!i_stall) begin
      e_adder = i_adder;
      e_rd1   = ref_read(ins[25:21]);
      e_rd2   = ref_read(ins[20:16]);
      e_sext  = 32'(signed'(ins[15:0]));
      e_rt    = ins[20:16];
      e_rd    = ins[15:11];
      e_jdir  = (i_adder & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
      e_ctrl  = ref_ctrl(ins[31:26]);
    end
    if (i_reg_write && i_write_reg != 5'd0) m_regs[i_write_reg] = i_write_data;
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    i_reg_write = 0; i_write_reg = 0; i_write_data = 0;
    i_stall = 0; i_flush = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    i_rst = 1'b0;
    i_instruccion = 32'h8C220004;
    i_adder = 32'h0000_1004;
    idle_inputs();
    model_clear();

    // 1. Reset held across an edge, $0 write ignored, bypass
    #1;
    check_all("rst_async");
    @(posedge i_clk); #1;
    check_all("rst_held");
    @(negedge i_clk);
    i_rst = 1'b1;

    i_instruccion = 32'h0000_0000;
    i_reg_write = 1; i_write_reg = 0; i_write_data = 32'hFFFF_FFFF;
    cycle("w0");
    idle_inputs();
    cycle("r0");
    check("r0_zero", o_read_data_1, 32'h0);

    i_instruccion = {6'h00, 5'd5, 5'd0, 5'd6, 11'h020};
    i_reg_write = 1; i_write_reg = 5; i_write_data = 32'hCAFE_BABE;
    cycle("bypass");
    check("bypass_rd1", o_read_data_1, 32'hCAFE_BABE);

    // 2. lw
    idle_inputs();
    i_reg_write = 1; i_write_reg = 1; i_write_data = 32'h10;
    cycle("w1");
    idle_inputs();
    i_instruccion = 32'h8C220004;
    cycle("lw");
    check("lw_rd1", o_read_data_1, 32'h10);
    check("lw_sext", o_sign_extend, 32'h4);
    check("lw_rt", {27'h0, o_rt}, 32'd2);
    check("lw_ctrl", {22'h0, dut_ctrl()}, {22'h0, 10'b0101011000});

    // 3. addi negative immediate
    i_instruccion = 32'h2003FFFC;
    cycle("addi");
    check("addi_sext", o_sign_extend, 32'hFFFF_FFFC);

    // 4. jump target
    i_instruccion = 32'h08000010; i_adder = 32'h0040_0004;
    cycle("j");
    check("j_dir", o_jump_dir, 32'h0000_0040);
    check("j_jump", {31'h0, o_Jump}, 32'd1);

    // 5. lw then R-type with stall, flush+stall, then release
    i_instruccion = 32'h8C220004;
    cycle("s_lw");
    i_instruccion = 32'h0022_1820;
    i_stall = 1;
    cycle("stall1");
    cycle("stall2");
    check("stall_hold", {22'h0, dut_ctrl()}, {22'h0, 10'b0101011000});
    i_flush = 1;
    cycle("flush");
    check("flush_ctrl", {22'h0, dut_ctrl()}, 32'h0);
    i_stall = 0; i_flush = 0;
    cycle("rtype");
    check("rtype_ctrl", {22'h0, dut_ctrl()}, {22'h0, 10'b1000001010});

    // 6. unknown opcode
    i_instruccion = 32'hFC22_0004;
    cycle("unk");
    check("unk_ctrl", {22'h0, dut_ctrl()}, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      case ($urandom_range(0, 6))
        0: op = 6'h00; 1: op = 6'h23; 2: op = 6'h2B; 3: op = 6'h04;
        4: op = 6'h08; 5: op = 6'h02; default: op = 6'($urandom);
      endcase
      i_instruccion = {op, 26'($urandom)};
      i_adder       = $urandom;
      i_reg_write   = ($urandom_range(0, 1) == 1);
      i_write_reg   = ($urandom_range(0, 3) == 0) ? i_instruccion[25:21] : 5'($urandom);
      i_write_data  = $urandom;
      i_stall       = ($urandom_range(0, 5) == 0);
      i_flush       = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    // Mid-stream async reset: outputs and bank clear without an edge
    idle_inputs();
    i_instruccion = {6'h00, 5'd5, 5'd1, 5'd3, 11'h020};
    cycle("pre_rst");
    #2;
    i_rst = 1'b0;
    #1;
    model_clear();
    check_all("mid_rst");
    @(negedge i_clk);
    i_rst = 1'b1;
    cycle("post_rst");
    check("post_rst_rd1", o_read_data_1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
